// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: self-test sequencer for the basic_gates datapath.
// It walks {A,B,C} through 0..7, holds each vector for DWELL_CYCLES cycles,
// then compares the six gate outputs against EXP_TABLE. It reports pass/fail,
// the error count and the first failing vector.
// Optional build macro: BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results of the last run are held
// APPLY | vec_out driven with the current index for DWELL_CYCLES cycles
// CHECK | one cycle: compare dut_out with the golden entry, advance index
// DONE  | one cycle: done pulse, pass valid
module gate_bist_ctrl #(
    parameter int          DWELL_CYCLES = 4,
    parameter logic [47:0] EXP_TABLE    = {6'h32, 6'h19, 6'h19, 6'h1A,
                                           6'h19, 6'h1A, 6'h1A, 6'h0D}
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] vec_out,
    input  logic [5:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_vec
);

    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] dwell_cnt;
    logic [2:0]       idx;
    logic [5:0]       exp_entry;
    logic             mismatch;

    // Golden entry for the vector being checked.
    always_comb begin
        exp_entry = EXP_TABLE[int'(idx) * 6 +: 6];
        mismatch  = (dut_out != exp_entry);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort wins over every other transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = APPLY;
                end
            end
            APPLY: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (dwell_cnt == DWELL_LAST) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (idx == 3'd7 || (STOP_ON_FAIL && mismatch)) begin
                    next_state = DONE;
                end else begin
                    next_state = APPLY;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, updated on each state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 3'd0;
            dwell_cnt <= '0;
            idx       <= 3'd0;
        end else begin
            busy <= (next_state != IDLE);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (next_state == APPLY) begin
                        idx       <= 3'd0;
                        vec_out   <= 3'd0;
                        dwell_cnt <= '0;
                        err_count <= 4'd0;
                        fail_vec  <= 3'd0;
                        pass      <= 1'b0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        vec_out   <= 3'd0;
                        idx       <= 3'd0;
                        dwell_cnt <= '0;
                        pass      <= 1'b0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        // Partial results are kept; this cycle's compare is dropped.
                        vec_out   <= 3'd0;
                        idx       <= 3'd0;
                        dwell_cnt <= '0;
                        pass      <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            if (err_count != 4'd8) begin
                                err_count <= err_count + 4'd1;
                            end
                            if (err_count == 4'd0) begin
                                fail_vec <= idx;
                            end
                        end
                        if (next_state == DONE) begin
                            done <= 1'b1;
                            pass <= (err_count == 4'd0) && !mismatch;
                        end else begin
                            idx       <= idx + 3'd1;
                            vec_out   <= idx + 3'd1;
                            dwell_cnt <= '0;
                        end
                    end
                end
                DONE: begin
                    vec_out <= 3'd0;
                    idx     <= 3'd0;
                    if (abort) begin
                        pass <= 1'b0;
                    end
                end
                default: begin
                    vec_out <= 3'd0;
                    idx     <= 3'd0;
                end
            endcase
        end
    end

endmodule
